// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_pkg
// Purpose  : Shared definitions for the alu_pipe slice: the 4-bit FuncCode
//            enumeration and the signed-overflow helpers used by the core.
// Contents : func_e  - operation encodings 0..15
//            ovf_add - overflow of A+B from the operand/result sign bits
//            ovf_sub - overflow of A-B from the operand/result sign bits
// Revision : 1.0 - initial release
// ============================================================================
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        ID   = 4'd2,
        NOT  = 4'd3,
        AND  = 4'd4,
        OR   = 4'd5,
        NAND = 4'd6,
        NOR  = 4'd7,
        XOR  = 4'd8,
        XNOR = 4'd9,
        LLS  = 4'd10,
        LRS  = 4'd11,
        ALS  = 4'd12,
        ARS  = 4'd13,
        TCP  = 4'd14,
        ZERO = 4'd15
    } func_e;

    // Arguments are sign bits: a/b are the operand MSBs, s the result MSB.
    // Width-independent, so one helper serves every DATA_W.
    function automatic logic ovf_add(input logic a, input logic b, input logic s);
        return (a == b) && (s != a);
    endfunction

    function automatic logic ovf_sub(input logic a, input logic b, input logic s);
        return (a != b) && (s != a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_core
// Purpose  : Purely combinational ALU datapath: (a, b, func) -> (c, ovf).
//            Shift codes take their amount from b[SHAMT_W-1:0].
// Ports    : a, b  in  DATA_W  operands
//            func  in  func_e  operation
//            c     out DATA_W  result
//            ovf   out 1       signed overflow (ADD, SUB, TCP only)
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  func_e             func,
    output logic [DATA_W-1:0] c,
    output logic              ovf
);

    localparam int                SHAMT_W   = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] C_MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [SHAMT_W-1:0] w_sh;
    logic [DATA_W-1:0]  w_sum;
    logic [DATA_W-1:0]  w_diff;

    // Only the low bits of B select the shift amount; upper bits are ignored.
    assign w_sh   = b[SHAMT_W-1:0];
    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        c   = '0;
        ovf = 1'b0;
        case (func)
            ADD: begin
                c   = w_sum;
                ovf = ovf_add(a[DATA_W-1], b[DATA_W-1], w_sum[DATA_W-1]);
            end
            SUB: begin
                c   = w_diff;
                ovf = ovf_sub(a[DATA_W-1], b[DATA_W-1], w_diff[DATA_W-1]);
            end
            ID:   c = a;
            NOT:  c = ~a;
            AND:  c = a & b;
            OR:   c = a | b;
            NAND: c = ~(a & b);
            NOR:  c = ~(a | b);
            XOR:  c = a ^ b;
            XNOR: c = ~(a ^ b);
            LLS,
            ALS:  c = a << w_sh;
            LRS:  c = a >> w_sh;
            ARS:  c = $unsigned($signed(a) >>> w_sh);
            TCP: begin
                // Negating the most negative value wraps back onto itself.
                c   = '0 - a;
                ovf = (a == C_MIN_NEG);
            end
            ZERO: c = '0;
            default: begin
                c   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined ALU with valid/ready handshakes on both
//            sides. S1 registers operands; S2 registers the core result.
//            Downstream stalls propagate back combinationally (no skid).
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_a/in_b/in_func    operand beat
//            out_valid/out_ready/out_c/out_ovf      result beat
//            ovf_clear/ovf_sticky                   only with the macro below
// Config   : `define ALU_PIPE_STICKY_OVF_EN adds a sticky overflow flag that
//            sets on any output transfer with out_ovf=1 and clears on
//            ovf_clear (set wins over a same-cycle clear).
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output logic              out_ovf
`ifdef ALU_PIPE_STICKY_OVF_EN
    ,
    input  logic              ovf_clear,
    output logic              ovf_sticky
`endif
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    func_e             r_s1_func;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [DATA_W-1:0] w_c;
    logic              w_ovf;

    // A stage may load whenever its downstream neighbour will be free by the
    // next edge; the chain reaches in_ready in the same cycle.
    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_func  <= ADD;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_func <= func_e'(in_func);
            end
        end
    end

    alu_pipe_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .func (r_s1_func),
        .c    (w_c),
        .ovf  (w_ovf)
    );

    // Result registers only load on a real beat, so bubbles keep the last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_c   <= w_c;
                out_ovf <= w_ovf;
            end
        end
    end

`ifdef ALU_PIPE_STICKY_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (DATA_W=16, plus one DATA_W=32
//            instance for a wide arithmetic shift). Expected results are
//            queued at input transfer and compared at output transfer.
// Config   : sticky-flag checks compile only with ALU_PIPE_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_func;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c;
    logic        out_ovf;

    logic        in_valid32;
    logic        in_ready32;
    logic [31:0] in_a32;
    logic [31:0] in_b32;
    logic [3:0]  in_func32;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] out_c32;
    logic        out_ovf32;

`ifdef ALU_PIPE_STICKY_OVF_EN
    logic        ovf_clear;
    logic        ovf_sticky;
    logic        ovf_clear32;
    logic        ovf_sticky32;
`endif

    int          n_chk;
    int          n_bad;
    int          n_rx;
    logic [16:0] sb_q[$];
    bit          done;

    alu_pipe #(.DATA_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_func   (in_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
`ifdef ALU_PIPE_STICKY_OVF_EN
        ,
        .ovf_clear (ovf_clear),
        .ovf_sticky(ovf_sticky)
`endif
    );

    alu_pipe #(.DATA_W(32)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_a      (in_a32),
        .in_b      (in_b32),
        .in_func   (in_func32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_c     (out_c32),
        .out_ovf   (out_ovf32)
`ifdef ALU_PIPE_STICKY_OVF_EN
        ,
        .ovf_clear (ovf_clear32),
        .ovf_sticky(ovf_sticky32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model written from the operation table using integer math.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
        int          sa;
        int          sb;
        int          r;
        int          sh;
        logic [15:0] c;
        logic        o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        r  = 0;
        c  = '0;
        o  = 1'b0;
        case (f)
            4'd0:  begin r = sa + sb; c = r[15:0]; o = (r > 32767) || (r < -32768); end
            4'd1:  begin r = sa - sb; c = r[15:0]; o = (r > 32767) || (r < -32768); end
            4'd2:  c = a;
            4'd3:  c = ~a;
            4'd4:  c = a & b;
            4'd5:  c = a | b;
            4'd6:  c = ~(a & b);
            4'd7:  c = ~(a | b);
            4'd8:  c = a ^ b;
            4'd9:  c = ~(a ^ b);
            4'd10, 4'd12: c = a << sh;
            4'd11: c = a >> sh;
            4'd13: begin
                c = a;
                for (int k = 0; k < sh; k++) c = {c[15], c[15:1]};
            end
            4'd14: begin r = -sa; c = r[15:0]; o = (r > 32767); end
            default: c = '0;
        endcase
        return {o, c};
    endfunction

    // Hold the beat until accepted; queue the expected result on transfer.
    task automatic send_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] f, input logic [16:0] exp);
        bit ok;
        int cnt;
        in_a     = a;
        in_b     = b;
        in_func  = f;
        in_valid = 1'b1;
        ok       = 1'b0;
        cnt      = 0;
        while (!ok && cnt < 64) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        else sb_q.push_back(exp);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        send_exp(a, b, f, model(a, b, f));
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (sb_q.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_rx++;
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {47'd0, out_ovf, out_c}, 64'h1_FFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                chk("result", {47'd0, out_ovf, out_c}, {47'd0, e});
            end
        end
    end

    initial begin
        n_chk       = 0;
        n_bad       = 0;
        n_rx        = 0;
        done        = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_func     = '0;
        out_ready   = 1'b1;
        in_valid32  = 1'b0;
        in_a32      = '0;
        in_b32      = '0;
        in_func32   = '0;
        out_ready32 = 1'b1;
`ifdef ALU_PIPE_STICKY_OVF_EN
        ovf_clear   = 1'b0;
        ovf_clear32 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_c", 64'(out_c), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // ADD overflow with latency check
        send_exp(16'h7FFF, 16'h0001, 4'd0, {1'b1, 16'h8000});
        chk("add_lat_1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("add_lat_2", 64'(out_valid), 64'd1);
        drain();

        // Directed arithmetic and shifts
        send_exp(16'h8000, 16'h0001, 4'd1,  {1'b1, 16'h7FFF});
        send_exp(16'h8000, 16'h0000, 4'd14, {1'b1, 16'h8000});
        send_exp(16'h0005, 16'h0000, 4'd14, {1'b0, 16'hFFFB});
        send_exp(16'h8010, 16'h0004, 4'd13, {1'b0, 16'hF801});
        send_exp(16'h8010, 16'h0004, 4'd11, {1'b0, 16'h0801});
        send_exp(16'h0001, 16'hFFFF, 4'd10, {1'b0, 16'h8000});
        send_exp(16'h1234, 16'h0000, 4'd13, {1'b0, 16'h1234});
        send_exp(16'hF0F0, 16'h0FF0, 4'd6,  {1'b0, 16'hFF0F});
        send_exp(16'hABCD, 16'h1234, 4'd15, {1'b0, 16'h0000});
        drain();

        // Back-to-back stream with a 4-cycle downstream stall
        n_rx = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'(i * 16'h1111), 16'(i + 1), 4'(i));
                done = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                chk("bp_full_in_ready", 64'(in_ready), 64'd0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_rx), 64'd8);

        // Random ops with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(16'h0003, 16'h0004, 4'd0);
        send(16'h0010, 16'h0001, 4'd1);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        send_exp(16'h0002, 16'h0003, 4'd0, {1'b0, 16'h0005});
        drain();

`ifdef ALU_PIPE_STICKY_OVF_EN
        send_exp(16'h7FFF, 16'h0001, 4'd0, {1'b1, 16'h8000});
        send_exp(16'h0001, 16'h0001, 4'd0, {1'b0, 16'h0002});
        send_exp(16'h00FF, 16'h0F0F, 4'd4, {1'b0, 16'h000F});
        drain();
        chk("sticky_hold", 64'(ovf_sticky), 64'd1);
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        chk("sticky_clear", 64'(ovf_sticky), 64'd0);
        send_exp(16'h8000, 16'h8000, 4'd0, {1'b1, 16'h0000});
        begin
            int cnt;
            cnt = 0;
            @(negedge clk);
            while (!out_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            chk("sticky_wait", 64'(out_valid), 64'd1);
        end
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        drain();
`endif

        // Wide arithmetic shift on the 32-bit instance
        in_a32     = 32'h8000_0000;
        in_b32     = 32'd31;
        in_func32  = 4'd13;
        in_valid32 = 1'b1;
        @(negedge clk);
        chk("w32_in_ready", 64'(in_ready32), 64'd1);
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        @(posedge clk);
        #1;
        chk("w32_out_valid", 64'(out_valid32), 64'd1);
        chk("w32_ars", 64'(out_c32), 64'hFFFF_FFFF);
        chk("w32_ovf", 64'(out_ovf32), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
